condicionador_entradas: RTL and testbench

- Front-end that generates the event inputs (a, b, c, d) consumed by the lighting-mode FSM.
- Conditions two raw push-buttons and a raw PIR presence sensor: synchronises, debounces and edge-detects them.
- Runs a presence/hold-off timer and emits one-clock event pulses: a = mode toggle, b = manual lamp toggle, d = presence start, c = absence timeout.
- Sits between board pins and the FSM; its outputs connect 1:1 to the FSM a/b/c/d inputs.

---
 rtl/condicionador_entradas.sv | 135 +++++++++++++
 tb/tb_condicionador_entradas.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/condicionador_entradas.sv
// Input conditioner for the lighting-mode FSM: synchronises, debounces and edge-detects
// two push-buttons and a PIR sensor, and generates the a/b/c/d event pulses.
module condicionador_entradas #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_modo,
    input  logic push_lamp,
    input  logic sensor_pir,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic presenca,
    output logic temporizando
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        VAZIO,
        OCUPADO,
        TEMPORIZANDO
    } estado_t;

    // bit 0 = push_modo, bit 1 = push_lamp, bit 2 = sensor_pir
    logic [2:0]      raw;
    logic [2:0]      sync_p0;
    logic [2:0]      sync_p1;
    logic [2:0]      deb_p2;
    logic [2:0]      deb_p3;
    logic [DB_W-1:0] db_cnt [3];

    estado_t           estado;
    estado_t           estado_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic              c_nxt;
    logic              d_nxt;

    assign raw = {sensor_pir, push_lamp, push_modo};

    // Stage p0/p1: two-flop synchroniser; p2: debounced level; p3: edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            deb_p2  <= '0;
            deb_p3  <= '0;
            a       <= 1'b0;
            b       <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            deb_p3  <= deb_p2;
            a       <= deb_p2[0] & ~deb_p3[0];
            b       <= deb_p2[1] & ~deb_p3[1];
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] == deb_p2[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    deb_p2[i] <= ~deb_p2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign presenca     = deb_p2[2];
    assign temporizando = (estado == TEMPORIZANDO);

    // Presence FSM: state register and registered event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= VAZIO;
            hold_cnt <= '0;
            c        <= 1'b0;
            d        <= 1'b0;
        end else begin
            estado   <= estado_nxt;
            hold_cnt <= hold_cnt_nxt;
            c        <= c_nxt;
            d        <= d_nxt;
        end
    end

    always_comb begin
        estado_nxt   = estado;
        hold_cnt_nxt = hold_cnt;
        c_nxt        = 1'b0;
        d_nxt        = 1'b0;
        case (estado)
            VAZIO: begin
                if (presenca) begin
                    estado_nxt = OCUPADO;
                    d_nxt      = 1'b1;
                end
            end
            OCUPADO: begin
                if (!presenca) begin
                    estado_nxt   = TEMPORIZANDO;
                    hold_cnt_nxt = '0;
                end
            end
            TEMPORIZANDO: begin
                // Returning presence wins over a coincident expiry: the lamp is still on
                if (presenca) begin
                    estado_nxt   = OCUPADO;
                    hold_cnt_nxt = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    estado_nxt   = VAZIO;
                    hold_cnt_nxt = '0;
                    c_nxt        = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                estado_nxt   = VAZIO;
                hold_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_condicionador_entradas.sv
// Directed bench for condicionador_entradas with DEBOUNCE_CYCLES=4 and HOLD_CYCLES=16.
module tb_condicionador_entradas;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic push_modo = 1'b0;
    logic push_lamp = 1'b0;
    logic sensor_pir = 1'b0;
    logic a, b, c, d, presenca, temporizando;

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0;
    int na, nb, nc, nd, ta, tb, tc, td;
    int tpr, tpf, ntemp, tt_first, tt_last, bad_cd;
    logic prev_pres = 1'b0;
    logic prev_temp = 1'b0;

    condicionador_entradas #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .push_modo(push_modo),
        .push_lamp(push_lamp),
        .sensor_pir(sensor_pir),
        .a(a),
        .b(b),
        .c(c),
        .d(d),
        .presenca(presenca),
        .temporizando(temporizando)
    );

    always #5 clk = ~clk;

    task automatic clear_counts();
        na = 0; nb = 0; nc = 0; nd = 0;
        ta = -1; tb = -1; tc = -1; td = -1;
        tpr = -1; tpf = -1; ntemp = 0; tt_first = -1; tt_last = -1;
        bad_cd = 0;
    endtask

    // Advance one clock and record what the outputs did on that edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (a) begin na++; ta = cyc; end
        if (b) begin nb++; tb = cyc; end
        if (c) begin nc++; tc = cyc; end
        if (d) begin nd++; td = cyc; end
        if (c && d) bad_cd++;
        if (presenca && !prev_pres) tpr = cyc;
        if (!presenca && prev_pres) tpf = cyc;
        if (temporizando) begin
            ntemp++;
            if (!prev_temp) tt_first = cyc;
            tt_last = cyc;
        end
        prev_pres = presenca;
        prev_temp = temporizando;
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        rst_n = 1'b0;
        push_modo = 1'b1; push_lamp = 1'b1; sensor_pir = 1'b1;
        repeat (5) step();
        outs = {a, b, c, d, presenca, temporizando};
        n_cmp++;
        if (outs !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 000000", outs);
        end
        push_modo = 1'b0; push_lamp = 1'b0; sensor_pir = 1'b0;
        rst_n = 1'b1;
        clear_counts();
        repeat (50) step();
        n_cmp++;
        if (na + nb + nc + nd !== 0) begin
            n_err++;
            $display("FAIL idle_pulses: got %0d pulses expected 0", na + nb + nc + nd);
        end
        n_cmp++;
        if ({presenca, temporizando} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_levels: presenca/temporizando got %b expected 00",
                     {presenca, temporizando});
        end
    endtask

    task automatic test_bounce();
        int n;
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            push_modo = (i % 2 == 0);
            step();
        end
        push_modo = 1'b1;
        n = cyc + 1;
        repeat (20) step();
        n_cmp++;
        if (na !== 1 || ta !== n + 6) begin
            n_err++;
            $display("FAIL bounce_a: got %0d pulses at edge %0d expected 1 at %0d", na, ta, n + 6);
        end
        n_cmp++;
        if (nb + nc + nd !== 0) begin
            n_err++;
            $display("FAIL bounce_others: got %0d b/c/d pulses expected 0", nb + nc + nd);
        end
        push_modo = 1'b0;
        clear_counts();
        repeat (12) step();
        n_cmp++;
        if (na !== 0) begin
            n_err++;
            $display("FAIL release_a: got %0d pulses expected 0", na);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        clear_counts();
        push_modo = 1'b1; push_lamp = 1'b1;
        n = cyc + 1;
        repeat (14) step();
        n_cmp++;
        if (na !== 1 || nb !== 1 || ta !== n + 6 || tb !== n + 6) begin
            n_err++;
            $display("FAIL simult_ab: got a=%0d@%0d b=%0d@%0d expected 1@%0d each",
                     na, ta, nb, tb, n + 6);
        end
        push_modo = 1'b0; push_lamp = 1'b0;
        repeat (12) step();
        clear_counts();
        push_modo = 1'b1;
        repeat (3) step();
        push_modo = 1'b0;
        repeat (15) step();
        push_lamp = 1'b1;
        repeat (3) step();
        push_lamp = 1'b0;
        repeat (15) step();
        n_cmp++;
        if (na !== 0 || nb !== 0) begin
            n_err++;
            $display("FAIL glitch_ab: got a=%0d b=%0d pulses expected 0 and 0", na, nb);
        end
    endtask

    task automatic test_presence();
        int n, m;
        clear_counts();
        sensor_pir = 1'b1;
        n = cyc + 1;
        repeat (10) step();
        sensor_pir = 1'b0;
        m = n + 15;
        repeat (40) step();
        n_cmp++;
        if (tpr !== n + 5 || nd !== 1 || td !== n + 6) begin
            n_err++;
            $display("FAIL pres_rise: presenca@%0d d=%0d@%0d expected presenca@%0d d=1@%0d",
                     tpr, nd, td, n + 5, n + 6);
        end
        n_cmp++;
        if (tpf !== m) begin
            n_err++;
            $display("FAIL pres_fall: got edge %0d expected %0d", tpf, m);
        end
        n_cmp++;
        if (ntemp !== 16 || tt_first !== m + 1 || tt_last !== m + 16) begin
            n_err++;
            $display("FAIL hold_window: got %0d cycles %0d..%0d expected 16 cycles %0d..%0d",
                     ntemp, tt_first, tt_last, m + 1, m + 16);
        end
        n_cmp++;
        if (nc !== 1 || tc !== m + 17) begin
            n_err++;
            $display("FAIL hold_c: got %0d pulses at %0d expected 1 at %0d", nc, tc, m + 17);
        end
    endtask

    task automatic test_represence();
        int f, f2;
        clear_counts();
        sensor_pir = 1'b1;
        repeat (10) step();
        sensor_pir = 1'b0;
        f = cyc + 1;
        while (cyc < f + 7) step();
        sensor_pir = 1'b1;
        repeat (12) step();
        n_cmp++;
        if (nc !== 0 || nd !== 1) begin
            n_err++;
            $display("FAIL repres_pulses: got c=%0d d=%0d expected c=0 d=1", nc, nd);
        end
        n_cmp++;
        if ({presenca, temporizando} !== 2'b10) begin
            n_err++;
            $display("FAIL repres_state: presenca/temporizando got %b expected 10",
                     {presenca, temporizando});
        end
        sensor_pir = 1'b0;
        f2 = cyc + 1;
        repeat (30) step();
        n_cmp++;
        if (nc !== 1 || tc !== f2 + 22 || tpf !== f2 + 5 || nd !== 1) begin
            n_err++;
            $display("FAIL repres_final: c=%0d@%0d fall@%0d d=%0d expected c=1@%0d fall@%0d d=1",
                     nc, tc, tpf, nd, f2 + 22, f2 + 5);
        end
    endtask

    task automatic test_reset_mid_hold();
        int f, n;
        logic [5:0] outs;
        sensor_pir = 1'b1;
        repeat (10) step();
        sensor_pir = 1'b0;
        f = cyc + 1;
        while (cyc < f + 10) step();
        n_cmp++;
        if (temporizando !== 1'b1) begin
            n_err++;
            $display("FAIL midhold_running: temporizando got %b expected 1", temporizando);
        end
        #2;
        rst_n = 1'b0;
        sensor_pir = 1'b1;
        #1;
        outs = {a, b, c, d, presenca, temporizando};
        n_cmp++;
        if (outs !== 6'b0) begin
            n_err++;
            $display("FAIL async_reset: got %b expected 000000", outs);
        end
        clear_counts();
        repeat (4) step();
        rst_n = 1'b1;
        n = cyc + 1;
        repeat (30) step();
        n_cmp++;
        if (nc !== 0) begin
            n_err++;
            $display("FAIL reset_cancel_c: got %0d pulses expected 0", nc);
        end
        n_cmp++;
        if (nd !== 1 || td !== n + 6 || presenca !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_d: d=%0d@%0d presenca=%b expected d=1@%0d presenca=1",
                     nd, td, presenca, n + 6);
        end
    endtask

    task automatic test_invariant();
        clear_counts();
        sensor_pir = 1'b0;
        push_modo = 1'b1;
        repeat (45) step();
        push_modo = 1'b0;
        n_cmp++;
        if (nc !== 1 || nd !== 0 || bad_cd !== 0 || na !== 1) begin
            n_err++;
            $display("FAIL final_absence: c=%0d d=%0d overlap=%0d a=%0d expected 1 0 0 1",
                     nc, nd, bad_cd, na);
        end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_bounce();
        test_simultaneous();
        test_presence();
        test_represence();
        test_reset_mid_hold();
        test_invariant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
